gray_conv_arbiter: RTL

- Shares one WIDTH-bit binary-to-Gray conversion stage between NREQ requesters.
- Round-robin arbitration grants one requester per cycle. Its binary word is converted (g[MSB]=b[MSB], g[i]=b[i+1]^b[i]) and captured in a single output register.
- Valid/ready handshakes on both sides.
- Sits between multiple binary-count producers (counters, pointers) and Gray-coded consumers (clock-crossing pointer logic, displays).

---
 rtl/gray_conv_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin arbiter feeding one shared binary-to-Gray
// stage. The granted requester's word is converted and captured in a single
// output register, with valid/ready on both sides and a wrapping count of
// completed output handshakes.
module gray_conv_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2,
  parameter int CNTW  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_gray,
  output logic [IDW-1:0]          out_id,
  input  logic                    out_ready,
  output logic [CNTW-1:0]         done_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic [IDW:0]     cand;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic [WIDTH-1:0] sel_bin;
  logic             slot_free;
  logic             accept;
  logic             handshake;

  // Output slot can take a new word when empty or when it drains this cycle.
  assign slot_free = (state_q == EMPTY) || out_ready;
  assign handshake = (state_q == FULL) && out_ready;
  assign accept    = grant_any && slot_free;

  // Round-robin search: first valid requester at or after ptr, wrapping at NREQ.
  // Candidates are reduced modulo NREQ, so ids >= NREQ can never be granted.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!grant_any && req_valid[cand[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  // Accept strobe is one-hot on the winner, and suppressed while in reset.
  always_comb begin
    req_ready = '0;
    if (grant_any && slot_free && rst_n) req_ready[grant_idx] = 1'b1;
  end

  // Mux the winner's word and convert: g[MSB]=b[MSB], g[i]=b[i+1]^b[i].
  always_comb begin
    sel_bin = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant_idx == IDW'(i)) sel_bin = req_data[i*WIDTH +: WIDTH];
    gray_d = sel_bin ^ (sel_bin >> 1);
    ptr_d  = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
    cnt_d  = cnt_q + CNTW'(1);
  end

  // EMPTY/FULL output FSM with registered result, id, pointer and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      gray_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (handshake) cnt_q <= cnt_d;
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= FULL;
            gray_q  <= gray_d;
            id_q    <= grant_idx;
            ptr_q   <= ptr_d;
          end
        end
        FULL: begin
          // A drain and a new accept in the same cycle keeps the slot full.
          if (accept) begin
            gray_q <= gray_d;
            id_q   <= grant_idx;
            ptr_q  <= ptr_d;
          end else if (out_ready) begin
            state_q <= EMPTY;
          end
        end
      endcase
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_gray  = gray_q;
  assign out_id    = id_q;
  assign done_cnt  = cnt_q;

endmodule
